vga_text_console: RTL and testbench
===================================

Name: vga_text_console

Overview:
- Character-stream front end that owns the write/read port (port B) of the VGA text framebuffer.
- Turns a byte stream from the CPU/bus into framebuffer writes: cursor tracking, control codes, line wrap, hardware scroll and clear.
- Sits directly upstream of framebuffer, driving framebuffer_addr/data/write_enable and framebuffer_addr_rd/rd_en, and consuming framebuffer_data_rd.
- Visible grid is 98 columns x 35 rows; cell address = row*98 + col.

Parameters:
- COLS, 98, characters per row
- ROWS, 35, visible rows
- RD_LATENCY, 2, clocks from fb_rd_en/fb_addr_rd sampled to fb_data_rd valid (fb_ram_dual port B)
- BLANK_CHAR, 8'h20, fill code for clear, scroll and backspace

Ports:
- clk  in  1  system clock, same clock as framebuffer
- rst  in  1  synchronous, active-high reset
- char_in  in  8  character/control code
- char_valid  in  1  char_in valid
- char_ready  out  1  block can accept char_in this cycle
- clear_req  in  1  single-cycle request to clear screen and home cursor
- busy  out  1  multi-cycle operation in progress
- cursor_col  out  7  current column, 0..COLS-1
- cursor_row  out  6  current row, 0..ROWS-1
- fb_addr  out  12  write address -> framebuffer_addr
- fb_data  out  8  write data -> framebuffer_data
- fb_we  out  1  write strobe -> framebuffer_write_enable
- fb_addr_rd  out  12  read address -> framebuffer_addr_rd
- fb_rd_en  out  1  read select -> framebuffer_rd_en; muxes port B address
- fb_data_rd  in  8  read data <- framebuffer_data_rd

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All outputs are registered.
- Reset: cursor (0,0); fb_we=0; fb_rd_en=0; addresses/data 0. The first state after reset is CLEAR_ALL, so busy=1 and char_ready=0 for COLS*ROWS cycles.
- rst mid-operation aborts immediately with no further writes, then restarts CLEAR_ALL.
- Port B exclusivity: fb_we and fb_rd_en are never both 1. fb_rd_en stays 0 in every cycle in which fb_we=1.
- char_ready = (state==IDLE) && !clear_req. A character is accepted on char_valid && char_ready.
- clear_req in IDLE wins over char_valid in the same cycle; the char is not accepted that cycle.
- clear_req outside IDLE is ignored.
- States:
  - IDLE
  - PUT: one write cycle
  - SCR_RD: assert read
  - SCR_WAIT: RD_LATENCY-1 cycles, read held
  - SCR_CAP: latch fb_data_rd
  - SCR_WR: write copy
  - CLR_LINE: blank last row
  - CLEAR_ALL
- Printable code (anything except 0x08, 0x0A, 0x0D; all 256 font codes allowed):
  - Accept at cycle N; PUT at N+1 with fb_we=1, fb_addr=row*COLS+col, fb_data=char.
  - col++. If the old col==COLS-1, do an implicit newline.
  - char_ready is 1 again at N+2 unless a scroll follows.
- 0x0D (CR): col=0, no write, back to IDLE next cycle.
- 0x0A (LF): col=0.
  - If row<ROWS-1: row++.
  - Else: scroll; row stays ROWS-1.
- 0x08 (BS):
  - If col>0: col--, then PUT of BLANK_CHAR at the new position.
  - If col==0: no write, no row change.
- Scroll: for src = COLS .. COLS*ROWS-1, ascending:
  - SCR_RD: fb_rd_en=1, fb_addr_rd=src. Held stable through SCR_WAIT.
  - SCR_CAP: at RD_LATENCY cycles after SCR_RD, capture fb_data_rd.
  - SCR_WR: fb_we=1, fb_addr=src-COLS.
  - Per cell: RD_LATENCY+2 cycles.
  - Then CLR_LINE writes BLANK_CHAR to (ROWS-1)*COLS .. ROWS*COLS-1, one per cycle.
- CLEAR_ALL: writes BLANK_CHAR to addresses 0..COLS*ROWS-1, one per cycle, then cursor (0,0).
- busy=1 in all states except IDLE. Cursor outputs update on the cycle the operation completes.
- Address arithmetic is 12-bit unsigned. COLS*ROWS ≤ 4096 is checked by an elaboration assertion.

Decomposition:
- Shared package vga_text_pkg: COLS, ROWS, BLANK_CHAR, control-code constants (CC_BS=8'h08, CC_LF=8'h0A, CC_CR=8'h0D), state enum.
- framebuffer imports the same COLS/ROWS.
- One sub-module, vga_fb_copier: sequences read->wait->capture->write for scroll and fill for clear. It takes src/dst/count/fill_mode, returns done, and owns the port-B signals.

Test Plan:
- Reset then idle:
  - fb_we pulses exactly 3430 times, addr 0..3429 ascending, data 8'h20.
  - fb_rd_en stays 0.
  - char_ready rises after the last write; cursor (0,0).
- Send 8'h41 at cycle N:
  - Single write at N+1, addr 0, data 8'h41.
  - cursor_col=1; char_ready=1 at N+2.
- Send 98 bytes 8'h30 from (0,0):
  - Last write addr 97.
  - Cursor (0,1) with no extra write.
- Scroll with a behavioural 2-cycle-latency RAM model; row r prefilled with 8'h40+r; cursor (10,34); send 8'h0A:
  - RAM row 0 = 8'h41 ... row 33 = 8'h62; row 34 all 8'h20.
  - Cursor (0,34); busy for 3332*4+98 cycles.
  - fb_we and fb_rd_en never both high.
- BS cases:
  - BS at (5,3): write addr 298, data 8'h20; cursor (4,3).
  - BS at (0,3): no write; cursor unchanged.
- Simultaneous events:
  - clear_req and char_valid in the same IDLE cycle: clear runs, char not accepted; char is accepted after busy falls and written at addr 0.
  - rst asserted mid-scroll: no write after the rst cycle, then a full CLEAR_ALL.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared geometry, control codes and state encodings for the VGA text console.
package vga_text_pkg;

   localparam int COLS       = 98;
   localparam int ROWS       = 35;
   localparam int RD_LATENCY = 2;

   localparam logic [7:0] BLANK_CHAR = 8'h20;
   localparam logic [7:0] CC_BS      = 8'h08;
   localparam logic [7:0] CC_LF      = 8'h0A;
   localparam logic [7:0] CC_CR      = 8'h0D;

   typedef enum logic [2:0] {
      IDLE, PUT, SCROLL, CLR_LINE, CLEAR_ALL
   } con_state_t;

   typedef enum logic [2:0] {
      CP_IDLE, SCR_RD, SCR_WAIT, SCR_CAP, SCR_WR, CP_FILL
   } cp_state_t;

   function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
      return 12'(row) * 12'(COLS) + 12'(col);
   endfunction

endpackage

// File: rtl/vga_fb_copier.sv
// Port-B sequencer: cell-by-cell copy (read, wait, capture, write) or constant fill.
// done_o is high during the final write, so the caller can chain the next job without a gap.
module vga_fb_copier
   import vga_text_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        fill_i,
   input  logic [11:0] src_i,
   input  logic [11:0] dst_i,
   input  logic [12:0] cnt_i,
   input  logic [7:0]  fill_dat_i,
   output logic        done_o,
   output logic [11:0] fb_addr_o,
   output logic [7:0]  fb_data_o,
   output logic        fb_we_o,
   output logic [11:0] fb_addr_rd_o,
   output logic        fb_rd_en_o,
   input  logic [7:0]  fb_data_rd_i
);

   cp_state_t   state_q, state_d;
   logic [11:0] src_q, src_d, dst_q, dst_d;
   logic [12:0] rem_q, rem_d;
   logic [7:0]  fill_q, fill_d, dat_q, dat_d;
   logic [3:0]  wait_q, wait_d;
   logic        we_q, rd_en_q;
   logic        last;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      fill_d  = fill_q;
      wait_d  = wait_q;
      dat_d   = dat_q;
      done_o  = 1'b0;
      last    = (rem_q == 13'd1);
      case (state_q)
         SCR_RD: begin
            state_d = (RD_LATENCY > 1) ? SCR_WAIT : SCR_CAP;
            wait_d  = 4'd1;
         end
         SCR_WAIT: begin
            if (wait_q >= 4'(RD_LATENCY - 1)) state_d = SCR_CAP;
            else                              wait_d  = wait_q + 4'd1;
         end
         SCR_CAP: begin
            state_d = SCR_WR;
            dat_d   = fb_data_rd_i;
         end
         SCR_WR, CP_FILL: begin
            done_o = last;
            if (last) begin
               state_d = CP_IDLE;
            end else begin
               rem_d = rem_q - 13'd1;
               dst_d = dst_q + 12'd1;
               if (state_q == SCR_WR) begin
                  src_d   = src_q + 12'd1;
                  state_d = SCR_RD;
               end
            end
         end
         default: ;
      endcase
      if (start_i) begin
         state_d = fill_i ? CP_FILL : SCR_RD;
         src_d   = src_i;
         dst_d   = dst_i;
         rem_d   = cnt_i;
         fill_d  = fill_dat_i;
      end
      if (state_d == CP_FILL) dat_d = fill_d;
   end

   // Strobes are decoded from the next state so they line up with the registered address.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CP_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         fill_q  <= '0;
         wait_q  <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         rd_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         fill_q  <= fill_d;
         wait_q  <= wait_d;
         dat_q   <= dat_d;
         we_q    <= (state_d == CP_FILL) || (state_d == SCR_WR);
         rd_en_q <= (state_d == SCR_RD) || (state_d == SCR_WAIT);
      end
   end

   assign fb_addr_o    = dst_q;
   assign fb_data_o    = dat_q;
   assign fb_we_o      = we_q;
   assign fb_addr_rd_o = src_q;
   assign fb_rd_en_o   = rd_en_q;

endmodule

// File: rtl/vga_text_console.sv
// Byte-stream text console: cursor tracking, CR/LF/BS handling, wrap, scroll and clear,
// driving framebuffer port B through vga_fb_copier.
module vga_text_console
   import vga_text_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  char_in,
   input  logic        char_valid,
   output logic        char_ready,
   input  logic        clear_req,
   output logic        busy,
   output logic [6:0]  cursor_col,
   output logic [5:0]  cursor_row,
   output logic [11:0] fb_addr,
   output logic [7:0]  fb_data,
   output logic        fb_we,
   output logic [11:0] fb_addr_rd,
   output logic        fb_rd_en,
   input  logic [7:0]  fb_data_rd
);

   if (COLS * ROWS > 4096) begin : g_size_chk
      $error("COLS*ROWS does not fit the 12-bit framebuffer address");
   end

   localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);
   localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);
   localparam logic [12:0] SCREEN_CNT = 13'(COLS * ROWS);
   localparam logic [12:0] COPY_CNT   = 13'(COLS * (ROWS - 1));
   localparam logic [12:0] LINE_CNT   = 13'(COLS);
   localparam logic [11:0] LINE_ADDR  = 12'(COLS * (ROWS - 1));

   con_state_t  state_q, state_d;
   logic [6:0]  col_q, col_d, pcol_q, pcol_d;
   logic [5:0]  row_q, row_d, prow_q, prow_d;
   logic        pscr_q, pscr_d, clr_go_q, clr_go_d;

   logic        cp_start, cp_fill, cp_done;
   logic [11:0] cp_src, cp_dst;
   logic [12:0] cp_cnt;
   logic [7:0]  cp_dat;

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      pcol_d   = pcol_q;
      prow_d   = prow_q;
      pscr_d   = pscr_q;
      clr_go_d = clr_go_q;
      cp_start = 1'b0;
      cp_fill  = 1'b1;
      cp_src   = '0;
      cp_dst   = '0;
      cp_cnt   = '0;
      cp_dat   = BLANK_CHAR;
      case (state_q)
         IDLE: begin
            if (clear_req) begin
               state_d  = CLEAR_ALL;
               cp_start = 1'b1;
               cp_cnt   = SCREEN_CNT;
            end else if (char_valid) begin
               case (char_in)
                  CC_CR: col_d = '0;
                  CC_LF: begin
                     if (row_q != LAST_ROW) begin
                        col_d = '0;
                        row_d = row_q + 6'd1;
                     end else begin
                        pcol_d   = '0;
                        prow_d   = row_q;
                        state_d  = SCROLL;
                        cp_start = 1'b1;
                        cp_fill  = 1'b0;
                        cp_src   = 12'(COLS);
                        cp_cnt   = COPY_CNT;
                     end
                  end
                  CC_BS: begin
                     if (col_q != '0) begin
                        state_d  = PUT;
                        cp_start = 1'b1;
                        cp_cnt   = 13'd1;
                        cp_dst   = cell_addr(row_q, col_q - 7'd1);
                        pcol_d   = col_q - 7'd1;
                        prow_d   = row_q;
                        pscr_d   = 1'b0;
                     end
                  end
                  default: begin
                     state_d  = PUT;
                     cp_start = 1'b1;
                     cp_cnt   = 13'd1;
                     cp_dst   = cell_addr(row_q, col_q);
                     cp_dat   = char_in;
                     pscr_d   = 1'b0;
                     prow_d   = row_q;
                     pcol_d   = col_q + 7'd1;
                     if (col_q == LAST_COL) begin
                        pcol_d = '0;
                        if (row_q == LAST_ROW) pscr_d = 1'b1;
                        else                   prow_d = row_q + 6'd1;
                     end
                  end
               endcase
            end
         end
         PUT: begin
            if (cp_done) begin
               if (pscr_q) begin
                  state_d  = SCROLL;
                  cp_start = 1'b1;
                  cp_fill  = 1'b0;
                  cp_src   = 12'(COLS);
                  cp_cnt   = COPY_CNT;
               end else begin
                  state_d = IDLE;
                  col_d   = pcol_q;
                  row_d   = prow_q;
               end
            end
         end
         SCROLL: begin
            if (cp_done) begin
               state_d  = CLR_LINE;
               cp_start = 1'b1;
               cp_dst   = LINE_ADDR;
               cp_cnt   = LINE_CNT;
            end
         end
         CLR_LINE: begin
            if (cp_done) begin
               state_d = IDLE;
               col_d   = pcol_q;
               row_d   = prow_q;
            end
         end
         CLEAR_ALL: begin
            // Entry from reset has no accepting cycle to launch the fill, so kick it here once.
            if (clr_go_q) begin
               cp_start = 1'b1;
               cp_cnt   = SCREEN_CNT;
               clr_go_d = 1'b0;
            end
            if (cp_done) begin
               state_d = IDLE;
               col_d   = '0;
               row_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= CLEAR_ALL;
         col_q    <= '0;
         row_q    <= '0;
         pcol_q   <= '0;
         prow_q   <= '0;
         pscr_q   <= 1'b0;
         clr_go_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         pcol_q   <= pcol_d;
         prow_q   <= prow_d;
         pscr_q   <= pscr_d;
         clr_go_q <= clr_go_d;
      end
   end

   vga_fb_copier u_copier (
      .clk          (clk),
      .rst          (rst),
      .start_i      (cp_start),
      .fill_i       (cp_fill),
      .src_i        (cp_src),
      .dst_i        (cp_dst),
      .cnt_i        (cp_cnt),
      .fill_dat_i   (cp_dat),
      .done_o       (cp_done),
      .fb_addr_o    (fb_addr),
      .fb_data_o    (fb_data),
      .fb_we_o      (fb_we),
      .fb_addr_rd_o (fb_addr_rd),
      .fb_rd_en_o   (fb_rd_en),
      .fb_data_rd_i (fb_data_rd)
   );

   assign char_ready = (state_q == IDLE) && !clear_req;
   assign busy       = (state_q != IDLE);
   assign cursor_col = col_q;
   assign cursor_row = row_q;

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console with a 2-cycle-latency framebuffer model on port B.
module tb_vga_text_console;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic        clear_req;
   logic        busy;
   logic [6:0]  cursor_col;
   logic [5:0]  cursor_row;
   logic [11:0] fb_addr;
   logic [7:0]  fb_data;
   logic        fb_we;
   logic [11:0] fb_addr_rd;
   logic        fb_rd_en;
   logic [7:0]  fb_data_rd;

   int total = 0;
   int bad   = 0;

   vga_text_console dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .clear_req  (clear_req),
      .busy       (busy),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .fb_we      (fb_we),
      .fb_addr_rd (fb_addr_rd),
      .fb_rd_en   (fb_rd_en),
      .fb_data_rd (fb_data_rd)
   );

   always #5 clk = ~clk;

   // Framebuffer model: write on the edge, read data two edges after the sampled address.
   logic [7:0] mem [0:4095];
   logic [7:0] rd_s1, rd_s2;
   logic       preload = 1'b0;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 4096; i++) mem[i] <= (i < 3430) ? 8'(8'h40 + i / 98) : 8'h00;
      end else if (fb_we) begin
         mem[fb_addr] <= fb_data;
      end
      if (fb_rd_en) rd_s1 <= mem[fb_addr_rd];
      rd_s2 <= rd_s1;
   end
   assign fb_data_rd = rd_s2;

   int          wr_total = 0;
   int          rd_total = 0;
   int          both_hi  = 0;
   logic [11:0] wlog_a [0:32767];
   logic [7:0]  wlog_d [0:32767];
   always @(negedge clk) begin
      if (fb_we) begin
         if (wr_total < 32768) begin
            wlog_a[wr_total] = fb_addr;
            wlog_d[wr_total] = fb_data;
         end
         wr_total++;
      end
      if (fb_rd_en) rd_total++;
      if (fb_we && fb_rd_en) both_hi++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] c);
      int n = 0;
      while (!char_ready && n < 20000) begin
         tick();
         n++;
      end
      if (!char_ready) begin
         total++;
         bad++;
         $error("FAIL send_timeout observed=busy required=ready");
      end
      char_in    = c;
      char_valid = 1'b1;
      tick();
      char_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit, output int cyc);
      cyc = 0;
      while (busy && cyc < limit) begin
         tick();
         cyc++;
      end
      if (busy) begin
         total++;
         bad++;
         $error("FAIL idle_timeout observed=busy required=idle");
      end
   endtask

   // Counts log entries that break the sequence addr=i, data=d starting at log index base.
   function automatic int fill_log_bad(input int base, input logic [7:0] d);
      int nbad = 0;
      for (int i = 0; i < 3430; i++) begin
         if (base + i >= 32768) nbad++;
         else if (wlog_a[base + i] !== 12'(i) || wlog_d[base + i] !== d) nbad++;
      end
      return nbad;
   endfunction

   function automatic int screen_bad(input bit scrolled);
      int nbad = 0;
      logic [7:0] e;
      for (int i = 0; i < 3430; i++) begin
         e = (scrolled && i < 3332) ? 8'(8'h41 + i / 98) : 8'h20;
         if (mem[i] !== e) nbad++;
      end
      return nbad;
   endfunction

   initial begin
      int base, rbase, hbase, cyc;
      rst        = 1'b1;
      char_in    = 8'h00;
      char_valid = 1'b0;
      clear_req  = 1'b0;
      repeat (3) tick();

      check("rst_we", fb_we, 1'b0);
      check("rst_rd_en", fb_rd_en, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_ready", char_ready, 1'b0);
      check("rst_cursor", {cursor_row, cursor_col}, 13'd0);
      check("rst_addr", {fb_addr, fb_addr_rd, fb_data}, 32'd0);

      // Power-up clear
      base  = wr_total;
      rbase = rd_total;
      rst   = 1'b0;
      wait_idle(5000, cyc);
      check("init_wr_count", wr_total - base, 3430);
      check("init_wr_seq", fill_log_bad(base, 8'h20), 0);
      check("init_no_read", rd_total - rbase, 0);
      check("init_ready", char_ready, 1'b1);
      check("init_cursor", {cursor_row, cursor_col}, 13'd0);

      // Single printable
      base = wr_total;
      send(8'h41);
      check("A_we", fb_we, 1'b1);
      check("A_addr", fb_addr, 12'd0);
      check("A_data", fb_data, 8'h41);
      check("A_ready_put", char_ready, 1'b0);
      tick();
      check("A_ready", char_ready, 1'b1);
      check("A_col", cursor_col, 7'd1);
      check("A_wr_count", wr_total - base, 1);

      // CR then a full row with wrap
      send(8'h0D);
      check("CR_col", cursor_col, 7'd0);
      check("CR_no_we", fb_we, 1'b0);
      base = wr_total;
      for (int i = 0; i < 98; i++) send(8'h30);
      tick();
      check("row_wr_count", wr_total - base, 98);
      check("row_last_addr", wlog_a[wr_total - 1], 12'd97);
      check("row_cursor", {cursor_row, cursor_col}, {6'd1, 7'd0});

      // Backspace at (5,3) and at (0,3)
      send(8'h0A);
      send(8'h0A);
      for (int i = 0; i < 5; i++) send(8'h78);
      tick();
      check("pre_bs_cursor", {cursor_row, cursor_col}, {6'd3, 7'd5});
      send(8'h08);
      check("bs_we", fb_we, 1'b1);
      check("bs_addr", fb_addr, 12'd298);
      check("bs_data", fb_data, 8'h20);
      tick();
      check("bs_cursor", {cursor_row, cursor_col}, {6'd3, 7'd4});
      send(8'h0D);
      base = wr_total;
      send(8'h08);
      check("bs0_we", fb_we, 1'b0);
      check("bs0_busy", busy, 1'b0);
      tick();
      check("bs0_cursor", {cursor_row, cursor_col}, {6'd3, 7'd0});
      check("bs0_wr_count", wr_total - base, 0);

      // clear_req and char_valid together
      clear_req  = 1'b1;
      char_in    = 8'h55;
      char_valid = 1'b1;
      #1;
      check("clr_ready_low", char_ready, 1'b0);
      base = wr_total;
      tick();
      clear_req = 1'b0;
      check("clr_busy", busy, 1'b1);
      check("clr_first_we", {fb_we, fb_addr}, {1'b1, 12'd0});
      cyc = 0;
      while (!char_ready && cyc < 5000) begin
         tick();
         cyc++;
      end
      check("clr_busy_cycles", cyc, 3430);
      check("clr_wr_count", wr_total - base, 3430);
      check("clr_wr_seq", fill_log_bad(base, 8'h20), 0);
      check("clr_cursor", {cursor_row, cursor_col}, 13'd0);
      tick();
      char_valid = 1'b0;
      check("clr_char_write", {fb_we, fb_addr, fb_data}, {1'b1, 12'd0, 8'h55});
      tick();
      check("clr_char_col", cursor_col, 7'd1);

      // Scroll from (10,34) over a preloaded screen
      send(8'h0D);
      for (int i = 0; i < 34; i++) send(8'h0A);
      for (int i = 0; i < 10; i++) send(8'h7A);
      tick();
      check("pre_scr_cursor", {cursor_row, cursor_col}, {6'd34, 7'd10});
      preload = 1'b1;
      tick();
      preload = 1'b0;
      base  = wr_total;
      rbase = rd_total;
      hbase = both_hi;
      send(8'h0A);
      check("scr_first_rd", {fb_rd_en, fb_addr_rd, fb_we}, {1'b1, 12'd98, 1'b0});
      cyc = 0;
      while (busy && cyc < 20000) begin
         tick();
         cyc++;
      end
      check("scr_busy_cycles", cyc, 3332 * 4 + 98);
      check("scr_cursor", {cursor_row, cursor_col}, {6'd34, 7'd0});
      check("scr_wr_count", wr_total - base, 3430);
      check("scr_rd_cycles", rd_total - rbase, 6664);
      check("scr_exclusive", both_hi - hbase, 0);
      check("scr_row0", mem[0], 8'h41);
      check("scr_row33", mem[33 * 98 + 50], 8'h62);
      check("scr_row34", mem[34 * 98 + 97], 8'h20);
      check("scr_screen", screen_bad(1'b1), 0);

      // Reset in the middle of a scroll
      send(8'h0A);
      repeat (100) tick();
      check("mid_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      base = wr_total;
      check("rst_mid_we", fb_we, 1'b0);
      check("rst_mid_rd", fb_rd_en, 1'b0);
      check("rst_mid_cursor", {cursor_row, cursor_col}, 13'd0);
      repeat (2) tick();
      check("rst_mid_no_wr", wr_total - base, 0);
      rst = 1'b0;
      wait_idle(5000, cyc);
      check("rst_clr_count", wr_total - base, 3430);
      check("rst_clr_seq", fill_log_bad(base, 8'h20), 0);
      check("rst_clr_screen", screen_bad(1'b0), 0);
      check("rst_clr_ready", char_ready, 1'b1);

      check("never_both_hi", both_hi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
